// File: rtl/ubbka_stage_pkg.sv
// Shared widths and types for the Brent-Kung adder operand stage.
package ubbka_stage_pkg;

    localparam int XW_DEF = 8;
    localparam int YW_DEF = 12;
    localparam int SW     = YW_DEF + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    typedef struct packed {
        logic [XW_DEF-1:0] x;
        logic [YW_DEF-1:0] y;
    } pair_t;

endpackage

// File: rtl/ubbka_opnd_buf.sv
// Two-entry ordered operand buffer; the head entry is held stable until popped.
module ubbka_opnd_buf
    import ubbka_stage_pkg::*;
#(
    parameter type T = pair_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output occ_e occ_o
);

    T     head_q, head_d;
    T     tail_q, tail_d;
    occ_e occ_q, occ_d;

    // Head is left untouched on a pop to EMPTY so the adder inputs keep their last value.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    head_d = data_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push_i && pop_i) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d = data_i;
                    occ_d  = OCC_FULL;
                end else if (pop_i) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop_i) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/ubbka_operand_stage.sv
// Valid/ready shell that feeds an external Brent-Kung adder and registers its sum.
// Defining OPSTAGE_CNT_EN adds a saturating count of consumed results on done_cnt_o.
module ubbka_operand_stage
    import ubbka_stage_pkg::*;
#(
    parameter int XW   = XW_DEF,
    parameter int YW   = YW_DEF,
    parameter int CNTW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_vld_i,
    output logic          in_rdy_o,
    input  logic [XW-1:0] in_x_i,
    input  logic [YW-1:0] in_y_i,
    output logic [XW-1:0] add_x_o,
    output logic [YW-1:0] add_y_o,
    input  logic [YW:0]   add_s_i,
    output logic          sum_vld_o,
    input  logic          sum_rdy_i,
    output logic [YW:0]   sum_o
`ifdef OPSTAGE_CNT_EN
    ,
    output logic [CNTW-1:0] done_cnt_o
`endif
);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } opnd_t;

    opnd_t       in_pair;
    opnd_t       head_pair;
    occ_e        occ;
    logic        push;
    logic        pop;
    logic        out_xfer;
    logic [YW:0] sum_q, sum_d;
    logic        sum_vld_q, sum_vld_d;

    assign in_pair.x = in_x_i;
    assign in_pair.y = in_y_i;

    assign in_rdy_o = (occ != OCC_FULL);
    assign push     = in_vld_i && in_rdy_o;
    assign out_xfer = sum_vld_q && sum_rdy_i;
    assign pop      = (occ != OCC_EMPTY) && (!sum_vld_q || sum_rdy_i);

    ubbka_opnd_buf #(
        .T(opnd_t)
    ) u_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .data_i (in_pair),
        .pop_i  (pop),
        .head_o (head_pair),
        .occ_o  (occ)
    );

    assign add_x_o = head_pair.x;
    assign add_y_o = head_pair.y;

    // A pop refills the result register even when the old result leaves in the same cycle.
    always_comb begin
        sum_d     = sum_q;
        sum_vld_d = sum_vld_q;
        if (pop) begin
            sum_d     = add_s_i;
            sum_vld_d = 1'b1;
        end else if (out_xfer) begin
            sum_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
        end
    end

    assign sum_vld_o = sum_vld_q;
    assign sum_o     = sum_q;

`ifdef OPSTAGE_CNT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_cnt_o = cnt_q;
`else
    logic cntw_unused;
    assign cntw_unused = (CNTW > 0);
`endif

endmodule

// File: tb/tb_ubbka_operand_stage.sv
// Randomized bench for ubbka_operand_stage against a queue-level reference model.
module tb_ubbka_operand_stage;
    import ubbka_stage_pkg::*;

    localparam int CNTW    = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic              clk = 1'b0;
    logic              rstN;
    logic              inVld;
    logic              inRdy;
    logic [XW_DEF-1:0] inX;
    logic [YW_DEF-1:0] inY;
    logic [XW_DEF-1:0] addX;
    logic [YW_DEF-1:0] addY;
    logic [SW-1:0]     addS;
    logic              sumVld;
    logic              sumRdy;
    logic [SW-1:0]     sumOut;
`ifdef OPSTAGE_CNT_EN
    logic [CNTW-1:0]   doneCnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending pairs in arrival order, the result register, and the adder-facing head.
    int mX[$];
    int mY[$];
    bit mVld;
    int mSum;
    int mHeadX;
    int mHeadY;
    int mCnt;

    always #5 clk = ~clk;

    assign addS = {{(SW-XW_DEF){1'b0}}, addX} + {1'b0, addY};

    ubbka_operand_stage #(
        .XW   (XW_DEF),
        .YW   (YW_DEF),
        .CNTW (CNTW)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .in_vld_i  (inVld),
        .in_rdy_o  (inRdy),
        .in_x_i    (inX),
        .in_y_i    (inY),
        .add_x_o   (addX),
        .add_y_o   (addY),
        .add_s_i   (addS),
        .sum_vld_o (sumVld),
        .sum_rdy_i (sumRdy),
        .sum_o     (sumOut)
`ifdef OPSTAGE_CNT_EN
        ,
        .done_cnt_o(doneCnt)
`endif
    );

    task automatic modelEdge(input bit vld, input int x, input int y, input bit rdy);
        bit push;
        bit xfer;
        bit pop;
        if (!rstN) begin
            mX.delete();
            mY.delete();
            mVld   = 1'b0;
            mSum   = 0;
            mHeadX = 0;
            mHeadY = 0;
            mCnt   = 0;
            return;
        end
        push = vld && (mX.size() < 2);
        xfer = mVld && rdy;
        pop  = (mX.size() > 0) && (!mVld || rdy);
        if (xfer && mCnt < CNT_MAX) mCnt++;
        if (pop) begin
            mSum = mX[0] + mY[0];
            mVld = 1'b1;
            void'(mX.pop_front());
            void'(mY.pop_front());
        end else if (xfer) begin
            mVld = 1'b0;
        end
        if (push) begin
            mX.push_back(x);
            mY.push_back(y);
        end
        if (mX.size() > 0) begin
            mHeadX = mX[0];
            mHeadY = mY[0];
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, and returns 1 ns later.
    task automatic cycle(input bit vld, input int x, input int y, input bit rdy);
        inVld  = vld;
        inX    = XW_DEF'(x);
        inY    = YW_DEF'(y);
        sumRdy = rdy;
        @(posedge clk);
        modelEdge(vld, x, y, rdy);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 4095), 1'b0);
        vectors++;
        if (sumVld !== 1'b0) begin miscompares++; $display("FAIL rst_sum_vld: got %b want 0", sumVld); end
        vectors++;
        if (sumOut !== '0) begin miscompares++; $display("FAIL rst_sum: got %h want 0", sumOut); end
        vectors++;
        if (addX !== '0 || addY !== '0) begin miscompares++; $display("FAIL rst_add: got %h/%h want 0/0", addX, addY); end
`ifdef OPSTAGE_CNT_EN
        vectors++;
        if (doneCnt !== '0) begin miscompares++; $display("FAIL rst_cnt: got %h want 0", doneCnt); end
`endif
        rstN = 1'b1;
        cycle(1'b0, 0, 0, 1'b0);
        vectors++;
        if (inRdy !== 1'b1) begin miscompares++; $display("FAIL rst_in_rdy: got %b want 1", inRdy); end
        vectors++;
        if (sumVld !== 1'b0 || addX !== '0 || addY !== '0) begin
            miscompares++;
            $display("FAIL rst_no_push: got vld=%b add=%h/%h want 0 0/0", sumVld, addX, addY);
        end
    endtask

    task automatic test_single_op();
        drain();
        cycle(1'b1, 'hFF, 'hFFF, 1'b1);
        vectors++;
        if (sumVld !== 1'b0) begin miscompares++; $display("FAIL single_early_vld: got %b want 0", sumVld); end
        vectors++;
        if (addX !== 8'hFF || addY !== 12'hFFF) begin miscompares++; $display("FAIL single_head: got %h/%h want ff/fff", addX, addY); end
        cycle(1'b0, 0, 0, 1'b1);
        vectors++;
        if (sumVld !== 1'b1 || sumOut !== 13'h10FE) begin
            miscompares++;
            $display("FAIL single_sum: got vld=%b sum=%h want 1 10fe", sumVld, sumOut);
        end
        cycle(1'b0, 0, 0, 1'b1);
        vectors++;
        if (sumVld !== 1'b0) begin miscompares++; $display("FAIL single_vld_drop: got %b want 0", sumVld); end
    endtask

    task automatic test_streaming();
        int xs[3]   = '{'h00, 'h80, 'h01};
        int ys[3]   = '{'h000, 'h7FF, 'hFFF};
        bit eVld[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int eSum[5] = '{0, 'h0000, 'h087F, 'h1000, 0};
        drain();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) cycle(1'b1, xs[c], ys[c], 1'b1);
            else cycle(1'b0, 0, 0, 1'b1);
            vectors++;
            if (sumVld !== eVld[c]) begin miscompares++; $display("FAIL stream_vld c%0d: got %b want %b", c, sumVld, eVld[c]); end
            if (eVld[c]) begin
                vectors++;
                if (sumOut !== 13'(eSum[c])) begin miscompares++; $display("FAIL stream_sum c%0d: got %h want %h", c, sumOut, 13'(eSum[c])); end
            end
            vectors++;
            if (inRdy !== 1'b1) begin miscompares++; $display("FAIL stream_in_rdy c%0d: got %b want 1", c, inRdy); end
        end
    endtask

    task automatic test_backpressure();
        int bx[4];
        int by[4];
        int got[$];
        int k = 0;
        bit take;
        for (int i = 0; i < 4; i++) begin
            bx[i] = $urandom_range(0, 255);
            by[i] = $urandom_range(0, 4095);
        end
        drain();
        for (int c = 0; c < 6; c++) begin
            take = (k < 4) && inRdy;
            cycle(k < 4, bx[k % 4], by[k % 4], 1'b0);
            if (take) k++;
            vectors++;
            if (sumVld !== mVld) begin miscompares++; $display("FAIL bp_vld c%0d: got %b want %b", c, sumVld, mVld); end
            if (mVld) begin
                vectors++;
                if (sumOut !== 13'(bx[0] + by[0])) begin miscompares++; $display("FAIL bp_hold c%0d: got %h want %h", c, sumOut, 13'(bx[0] + by[0])); end
            end
        end
        vectors++;
        if (k !== 3) begin miscompares++; $display("FAIL bp_accept_count: got %0d want 3", k); end
        vectors++;
        if (inRdy !== 1'b0) begin miscompares++; $display("FAIL bp_in_rdy: got %b want 0", inRdy); end
        for (int c = 0; c < 10; c++) begin
            if (sumVld) got.push_back(int'(sumOut));
            take = (k < 4) && inRdy;
            cycle(k < 4, bx[k % 4], by[k % 4], 1'b1);
            if (take) k++;
        end
        vectors++;
        if (got.size() != 4) begin miscompares++; $display("FAIL bp_out_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            vectors++;
            if (got[i] != bx[i] + by[i]) begin miscompares++; $display("FAIL bp_order %0d: got %h want %h", i, got[i], bx[i] + by[i]); end
        end
    endtask

    task automatic test_push_pop();
        int x;
        int y;
        int prevSum;
        drain();
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 4095);
        cycle(1'b1, x, y, 1'b1);
        prevSum = x + y;
        for (int c = 0; c < 10; c++) begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 4095);
            cycle(1'b1, x, y, 1'b1);
            vectors++;
            if (inRdy !== 1'b1) begin miscompares++; $display("FAIL pp_in_rdy c%0d: got %b want 1", c, inRdy); end
            vectors++;
            if (addX !== 8'(x) || addY !== 12'(y)) begin miscompares++; $display("FAIL pp_head c%0d: got %h/%h want %h/%h", c, addX, addY, 8'(x), 12'(y)); end
            vectors++;
            if (sumVld !== 1'b1 || sumOut !== 13'(prevSum)) begin
                miscompares++;
                $display("FAIL pp_sum c%0d: got vld=%b sum=%h want 1 %h", c, sumVld, sumOut, 13'(prevSum));
            end
            prevSum = x + y;
        end
    endtask

    task automatic test_random();
        drain();
        for (int c = 0; c < 200; c++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 255), $urandom_range(0, 4095), $urandom_range(0, 9) < 6);
            vectors++;
            if (inRdy !== (mX.size() < 2)) begin miscompares++; $display("FAIL rand_in_rdy c%0d: got %b want %b", c, inRdy, mX.size() < 2); end
            vectors++;
            if (sumVld !== mVld) begin miscompares++; $display("FAIL rand_vld c%0d: got %b want %b", c, sumVld, mVld); end
            if (mVld) begin
                vectors++;
                if (sumOut !== 13'(mSum)) begin miscompares++; $display("FAIL rand_sum c%0d: got %h want %h", c, sumOut, 13'(mSum)); end
            end
            vectors++;
            if (addX !== 8'(mHeadX) || addY !== 12'(mHeadY)) begin
                miscompares++;
                $display("FAIL rand_head c%0d: got %h/%h want %h/%h", c, addX, addY, 8'(mHeadX), 12'(mHeadY));
            end
        end
    endtask

`ifdef OPSTAGE_CNT_EN
    task automatic test_counter();
        rstN = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);
        rstN = 1'b1;
        for (int c = 0; c < 23; c++) begin
            cycle(c < 20, $urandom_range(0, 255), $urandom_range(0, 4095), 1'b1);
            vectors++;
            if (doneCnt !== CNTW'(mCnt)) begin miscompares++; $display("FAIL cnt_track c%0d: got %h want %h", c, doneCnt, CNTW'(mCnt)); end
        end
        vectors++;
        if (doneCnt !== 4'hF) begin miscompares++; $display("FAIL cnt_saturate: got %h want f", doneCnt); end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 4095), 1'b1);
            vectors++;
            if (doneCnt !== 4'hF) begin miscompares++; $display("FAIL cnt_hold c%0d: got %h want f", c, doneCnt); end
        end
        rstN = 1'b0;
        cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 4095), 1'b1);
        rstN = 1'b1;
        vectors++;
        if (doneCnt !== '0) begin miscompares++; $display("FAIL cnt_reset: got %h want 0", doneCnt); end
        vectors++;
        if (sumVld !== 1'b0 || inRdy !== 1'b1) begin miscompares++; $display("FAIL cnt_reset_flush: got vld=%b rdy=%b want 0 1", sumVld, inRdy); end
    endtask
`endif

    initial begin
        rstN   = 1'b0;
        inVld  = 1'b0;
        inX    = '0;
        inY    = '0;
        sumRdy = 1'b0;
        test_reset();
        test_single_op();
        test_streaming();
        test_backpressure();
        test_push_pop();
        test_random();
`ifdef OPSTAGE_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
